// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the register dump unit.
// REG_DUMP_CHECKSUM_EN adds the checksum state to the dump FSM encoding.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StSend = 3'd2,
`ifdef REG_DUMP_CHECKSUM_EN
        StCsum = 3'd3,
`endif
        StFin  = 3'd4
    } dump_state_e;

endpackage

// File: rtl/reg_dump_unit_if.sv
// Beat stream from the register dump unit to its sink (valid/ready handshake).
interface reg_dump_unit_if #(
    parameter int unsigned DATA_W = 32
);

    logic                            out_valid;
    logic                            out_ready;
    logic [cpu_pkg::REG_ADDR_W-1:0]  out_addr;
    logic [DATA_W-1:0]               out_data;
    logic                            out_last;
    logic                            out_csum;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        output out_last,
        output out_csum,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        input  out_last,
        input  out_csum,
        output out_ready
    );

endinterface

// File: rtl/reg_dump_unit.sv
// Streams a range of architectural registers out as valid/ready beats.
// REG_DUMP_CHECKSUM_EN appends an XOR checksum beat after the data beats.
module reg_dump_unit
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [REG_ADDR_W-1:0] first_addr,
    input  logic [REG_ADDR_W-1:0] last_addr,
    output logic [REG_ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0]     rf_read_data,
    reg_dump_unit_if.master       out,
    output logic                  busy,
    output logic                  done
);

    localparam logic [REG_ADDR_W-1:0] MaxIdx = REG_ADDR_W'(NUM_REGS - 1);

`ifdef REG_DUMP_CHECKSUM_EN
    localparam bit CsumEn = 1'b1;
`else
    localparam bit CsumEn = 1'b0;
`endif

    dump_state_e           state_q, state_d;
    logic [REG_ADDR_W-1:0] cursor_q, cursor_d;
    logic [REG_ADDR_W-1:0] end_q, end_d;
    logic                  valid_q, valid_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  last_q, last_d;
    logic [REG_ADDR_W-1:0] last_clamped;
    logic                  capture;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]     acc_q, acc_d;
`endif

    // Indices beyond the implemented register file are never read.
    assign last_clamped = (last_addr > MaxIdx) ? MaxIdx : last_addr;

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        end_d    = end_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        last_d   = last_q;
        capture  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
        acc_d    = acc_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    acc_d = '0;
`endif
                    if (first_addr <= last_clamped) begin
                        cursor_d = first_addr;
                        end_d    = last_clamped;
                        state_d  = StLoad;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StLoad: begin
                capture = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (out.out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    acc_d = acc_q ^ data_q;
`endif
                    // End is detected on the beat address, so cursor wrap is harmless.
                    if (addr_q != end_q) begin
                        capture = 1'b1;
                    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                        addr_d  = '0;
                        data_d  = acc_q ^ data_q;
                        last_d  = 1'b1;
                        state_d = StCsum;
`else
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = StFin;
`endif
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            StCsum: begin
                if (out.out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = StFin;
                end
            end
`endif
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (capture) begin
            valid_d  = 1'b1;
            addr_d   = cursor_q;
            data_d   = rf_read_data;
            last_d   = (cursor_q == end_q) && !CsumEn;
            cursor_d = cursor_q + REG_ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cursor_q <= '0;
            end_q    <= '0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            end_q    <= end_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            last_q   <= last_d;
`ifdef REG_DUMP_CHECKSUM_EN
            acc_q    <= acc_d;
`endif
        end
    end

    assign rf_read_addr  = cursor_q;
    assign out.out_valid = valid_q;
    assign out.out_addr  = addr_q;
    assign out.out_data  = data_q;
    assign out.out_last  = last_q;
`ifdef REG_DUMP_CHECKSUM_EN
    assign out.out_csum  = (state_q == StCsum);
`else
    assign out.out_csum  = 1'b0;
`endif
    assign busy = (state_q != StIdle);
    assign done = (state_q == StFin);

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed and randomized checks of reg_dump_unit against a queue-based beat model.
module tb_reg_dump_unit;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        last;
        logic        cs;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  first_addr = '0;
    logic [4:0]  last_addr = '0;
    logic [4:0]  rf_read_addr;
    logic [31:0] rf_read_data;
    logic        busy;
    logic        done;
    logic [31:0] regs [32];
    logic [31:0] last_csum;

    logic        out_valid;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_csum;

    int n_asserts = 0;
    int n_fail = 0;

    reg_dump_unit_if #(.DATA_W(32)) out_if ();

    reg_dump_unit #(
        .NUM_REGS(32),
        .DATA_W  (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .first_addr  (first_addr),
        .last_addr   (last_addr),
        .rf_read_addr(rf_read_addr),
        .rf_read_data(rf_read_data),
        .out         (out_if),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    assign rf_read_data = regs[rf_read_addr];
    assign out_valid    = out_if.out_valid;
    assign out_addr     = out_if.out_addr;
    assign out_data     = out_if.out_data;
    assign out_last     = out_if.out_last;
    assign out_csum     = out_if.out_csum;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Model: one beat per index first..last, optional XOR checksum beat, last flag on final beat.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                            input bit poke);
        beat_t       exp_q[$];
        beat_t       b;
        logic [31:0] acc = '0;
        logic [38:0] prev = '0;
        int          k = 0;
        bit          seen_done = 0;
        bit          finished = 0;
        bit          held = 0;
        bit          rdy;
        if (f <= l) begin
            for (int i = int'(f); i <= int'(l); i++) begin
                b.a = 5'(i);
                b.d = regs[i];
                b.last = 1'b0;
                b.cs = 1'b0;
                acc ^= regs[i];
                exp_q.push_back(b);
            end
`ifdef REG_DUMP_CHECKSUM_EN
            b.a = '0;
            b.d = acc;
            b.last = 1'b1;
            b.cs = 1'b1;
            exp_q.push_back(b);
`else
            exp_q[exp_q.size()-1].last = 1'b1;
`endif
        end
        last_csum = '0;
        @(negedge clk);
        start = 1'b1;
        first_addr = f;
        last_addr = l;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (seen_done) begin
                check("idle_busy", busy, 0);
                check("single_done", done, 0);
                check("idle_valid", out_valid, 0);
                finished = 1;
                break;
            end
            if (cyc == 1) check("no_beat_in_load", out_valid, 0);
            if (held) check("held_stable", {out_valid, out_addr, out_data, out_last, out_csum},
                            {1'b1, prev});
            if (done) begin
                seen_done = 1;
                check("beats_before_done", exp_q.size(), 0);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2) == 0;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_if.out_ready = rdy;
            if (out_valid && rdy) begin
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    if (mode == 0) check("beat_cycle", cyc, 2 + k);
                    check("beat", {out_addr, out_data, out_last, out_csum}, exp_q[0]);
                    if (out_csum) last_csum = out_data;
                    void'(exp_q.pop_front());
                    k++;
                end
            end
            held = out_valid && !rdy;
            prev = {out_addr, out_data, out_last, out_csum};
            // A start while busy must not disturb the running dump.
            start = poke && (cyc == 3);
            if (start) begin
                first_addr = 5'($urandom);
                last_addr = 5'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("dump_finished", finished, 1);
    endtask

    initial begin
        int f;
        int l;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        out_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_addr", out_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_csum", out_csum, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cursor", rf_read_addr, 0);
        reset = 1'b0;

        regs[1] = 32'h11;
        regs[2] = 32'h22;
        regs[3] = 32'h33;
        run_dump(5'd1, 5'd3, 0, 0);
        run_dump(5'd1, 5'd3, 1, 0);

        regs[31] = 32'hDEADBEEF;
        run_dump(5'd31, 5'd31, 0, 0);
        run_dump(5'd5, 5'd2, 0, 0);

        // Reset while the third beat of a full dump is on the bus.
        @(negedge clk);
        out_if.out_ready = 1'b1;
        start = 1'b1;
        first_addr = 5'd0;
        last_addr = 5'd31;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_beat3_addr", {out_valid, out_addr}, {1'b1, 5'd2});
        check("mid_beat3_data", out_data, regs[2]);
        reset = 1'b1;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", {busy, done}, 0);
        end
        run_dump(5'd7, 5'd12, 0, 0);

        regs[1] = 32'h0000F0F0;
        regs[2] = 32'h00000FF0;
        run_dump(5'd1, 5'd2, 0, 0);
`ifdef REG_DUMP_CHECKSUM_EN
        check("csum_value", last_csum, 32'h0000FF00);
`endif

        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            f = $urandom_range(0, 31);
            l = $urandom_range(f, 31);
            if (it % 4 == 3 && f > 0) begin
                l = f - 1;
            end
            run_dump(5'(f), 5'(l), 2, l > f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
